// File: rtl/alarm_clock_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alarm_clock_ctrl_pkg
// Shared constants for the alarm clock controller: time-field width, field
// limits, alarm FSM state encoding, counter width and a range-check helper
// used to accept or reject user loads.
// ---------------------------------------------------------------------------
package alarm_clock_ctrl_pkg;

    localparam int TIME_W = 6;
    localparam int CNT_W  = 8;

    localparam logic [TIME_W-1:0] HOUR_MAX = 6'd23;
    localparam logic [TIME_W-1:0] MIN_MAX  = 6'd59;
    localparam logic [TIME_W-1:0] SEC_MAX  = 6'd59;

    // Alarm FSM encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RING   = 2'd1;
    localparam logic [1:0] ST_SNOOZE = 2'd2;

    // A load is only accepted when both fields are legal
    function automatic logic time_in_range(input logic [TIME_W-1:0] hour,
                                           input logic [TIME_W-1:0] minute);
        return (hour <= HOUR_MAX) && (minute <= MIN_MAX);
    endfunction

endpackage

// File: rtl/alarm_clock_ctrl_mod_counter.sv
// ---------------------------------------------------------------------------
// mod_counter
// Modulo-N time-field counter, chained for seconds/minutes/hours.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   srst         synchronous clear (highest synchronous priority)
//   load         synchronous load of load_val
//   load_val     value to load
//   en           advance by one (wraps MODULUS-1 -> 0)
//   count        current value (registered)
//   carry        en while count is at MODULUS-1; enables the next stage
// ---------------------------------------------------------------------------
module mod_counter
    import alarm_clock_ctrl_pkg::*;
#(
    parameter int MODULUS = 60
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              srst,
    input  logic              load,
    input  logic [TIME_W-1:0] load_val,
    input  logic              en,
    output logic [TIME_W-1:0] count,
    output logic              carry
);

    localparam logic [TIME_W-1:0] LAST = TIME_W'(MODULUS - 1);

    // Wrap-around carry feeds the enable of the next field
    assign carry = en && (count == LAST);

    // Counter register: clear, load, advance or hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 6'd0;
        end else if (srst) begin
            count <= 6'd0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= (count == LAST) ? 6'd0 : count + 6'd1;
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/alarm_clock_ctrl.sv
// ---------------------------------------------------------------------------
// alarm_clock_ctrl
// 24-hour binary timekeeper with one programmable alarm, snooze and
// auto-silence.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   tick_1s                         one-second strobe
//   load_time / load_alarm          load set_hour:set_min into time / alarm
//   set_hour, set_min               load values (out-of-range loads ignored)
//   alarm_en                        alarm armed (level)
//   stop_alarm, snooze              user controls (pulses)
//   tmp_hour/tmp_minute/tmp_second  current time
//   alarm_hour, alarm_min           stored alarm time
//   alarm                           registered ringing indicator
// ---------------------------------------------------------------------------
module alarm_clock_ctrl
    import alarm_clock_ctrl_pkg::*;
#(
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_SECONDS = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_1s,
    input  logic        load_time,
    input  logic        load_alarm,
    input  logic [5:0]  set_hour,
    input  logic [5:0]  set_min,
    input  logic        alarm_en,
    input  logic        stop_alarm,
    input  logic        snooze,
    output logic [5:0]  tmp_hour,
    output logic [5:0]  tmp_minute,
    output logic [5:0]  tmp_second,
    output logic [5:0]  alarm_hour,
    output logic [5:0]  alarm_min,
    output logic        alarm
);

    localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_SECONDS - 1);
    localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_SECONDS - 1);

    logic              time_load_s;
    logic              alarm_load_s;
    logic              tick_ok_s;
    logic              sec_carry_s;
    logic              min_carry_s;
    logic              hour_carry_s;
    logic [TIME_W-1:0] nxt_min_s;
    logic [TIME_W-1:0] nxt_hour_s;
    logic              match_s;

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [CNT_W-1:0]  ring_cnt_r;
    logic [CNT_W-1:0]  ring_cnt_nxt_s;
    logic [CNT_W-1:0]  snooze_cnt_r;
    logic [CNT_W-1:0]  snooze_cnt_nxt_s;
    logic              alarm_r;
    logic [5:0]        alarm_hour_r;
    logic [5:0]        alarm_min_r;

    assign time_load_s  = load_time  && time_in_range(set_hour, set_min);
    assign alarm_load_s = load_alarm && time_in_range(set_hour, set_min);
    // A time load wins over a coincident tick, which is dropped
    assign tick_ok_s    = tick_1s && !time_load_s;

    mod_counter #(.MODULUS(60)) u_sec (
        .clk(clk), .rst_n(rst_n), .srst(time_load_s), .load(1'b0),
        .load_val(6'd0), .en(tick_ok_s), .count(tmp_second), .carry(sec_carry_s)
    );

    mod_counter #(.MODULUS(60)) u_min (
        .clk(clk), .rst_n(rst_n), .srst(1'b0), .load(time_load_s),
        .load_val(set_min), .en(sec_carry_s), .count(tmp_minute), .carry(min_carry_s)
    );

    mod_counter #(.MODULUS(24)) u_hour (
        .clk(clk), .rst_n(rst_n), .srst(1'b0), .load(time_load_s),
        .load_val(set_hour), .en(min_carry_s), .count(tmp_hour), .carry(hour_carry_s)
    );

    // Only a tick that rolls the seconds to :00 can land on the alarm time,
    // so the match looks at the post-tick minute/hour.
    assign nxt_min_s  = min_carry_s  ? 6'd0 : tmp_minute + 6'd1;
    assign nxt_hour_s = hour_carry_s ? 6'd0 : (min_carry_s ? tmp_hour + 6'd1 : tmp_hour);
    assign match_s    = tick_ok_s && sec_carry_s && alarm_en &&
                        (nxt_min_s == alarm_min_r) && (nxt_hour_s == alarm_hour_r);

    // Alarm time registers, updated only on an in-range load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_hour_r <= 6'd0;
            alarm_min_r  <= 6'd0;
        end else if (alarm_load_s) begin
            alarm_hour_r <= set_hour;
            alarm_min_r  <= set_min;
        end else begin
            alarm_hour_r <= alarm_hour_r;
            alarm_min_r  <= alarm_min_r;
        end
    end

    // Alarm FSM next-state; branch order encodes the event priority
    always_comb begin
        state_nxt_s      = state_r;
        ring_cnt_nxt_s   = ring_cnt_r;
        snooze_cnt_nxt_s = snooze_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (match_s) begin
                    state_nxt_s    = ST_RING;
                    ring_cnt_nxt_s = 8'd0;
                end else begin
                    state_nxt_s    = ST_IDLE;
                end
            end
            ST_RING: begin
                if (!alarm_en || stop_alarm) begin
                    state_nxt_s      = ST_IDLE;
                end else if (snooze) begin
                    state_nxt_s      = ST_SNOOZE;
                    snooze_cnt_nxt_s = 8'd0;
                end else if (tick_1s) begin
                    if (ring_cnt_r == RING_LAST) begin
                        state_nxt_s    = ST_IDLE;
                    end else begin
                        ring_cnt_nxt_s = ring_cnt_r + 8'd1;
                    end
                end else begin
                    state_nxt_s      = ST_RING;
                end
            end
            ST_SNOOZE: begin
                if (!alarm_en || stop_alarm) begin
                    state_nxt_s = ST_IDLE;
                end else if (tick_1s) begin
                    if (snooze_cnt_r == SNOOZE_LAST) begin
                        state_nxt_s    = ST_RING;
                        ring_cnt_nxt_s = 8'd0;
                    end else begin
                        snooze_cnt_nxt_s = snooze_cnt_r + 8'd1;
                    end
                end else begin
                    state_nxt_s = ST_SNOOZE;
                end
            end
            default: begin
                state_nxt_s      = ST_IDLE;
                ring_cnt_nxt_s   = 8'd0;
                snooze_cnt_nxt_s = 8'd0;
            end
        endcase
    end

    // FSM state, counters and registered alarm output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            ring_cnt_r   <= 8'd0;
            snooze_cnt_r <= 8'd0;
            alarm_r      <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            ring_cnt_r   <= ring_cnt_nxt_s;
            snooze_cnt_r <= snooze_cnt_nxt_s;
            alarm_r      <= (state_nxt_s == ST_RING);
        end
    end

    assign alarm      = alarm_r;
    assign alarm_hour = alarm_hour_r;
    assign alarm_min  = alarm_min_r;

endmodule

// File: doc/alarm_clock_ctrl.md
ALARM_CLOCK_CTRL -- requirements
Module: alarm_clock_ctrl

Interface
REQ-001 Parameter RING_SECONDS, default 60: one-second ticks the alarm rings before auto-silence; legal range 1..255.
REQ-002 Parameter SNOOZE_SECONDS, default 30: one-second ticks spent in snooze before re-ringing; legal range 1..255.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 tick_1s  input  1  one-clk-wide pulse, once per second, from the prescaler.
REQ-006 load_time  input  1  one-clk pulse; load set_hour/set_min into the time counters.
REQ-007 load_alarm  input  1  one-clk pulse; load set_hour/set_min into the alarm registers.
REQ-008 set_hour  input  6  hour value for either load, binary 0..23.
REQ-009 set_min  input  6  minute value for either load, binary 0..59.
REQ-010 alarm_en  input  1  level; alarm armed when 1.
REQ-011 stop_alarm  input  1  one-clk pulse; silence and cancel the alarm.
REQ-012 snooze  input  1  one-clk pulse; defer the ringing alarm.
REQ-013 tmp_hour, tmp_minute, tmp_second  output  6 each  binary current time; drives the BCD display converter directly.
REQ-014 alarm_hour, alarm_min  output  6 each  binary stored alarm time; drives the converter's alarm-digit inputs.
REQ-015 alarm  output  1  registered; 1 while ringing.

Function
REQ-016 On each tick_1s, tmp_second SHALL increment; 59 wraps to 0 with a carry to tmp_minute; minute 59 wraps to 0 with a carry to tmp_hour; hour 23 wraps to 0 (23:59:59 -> 00:00:00).
REQ-017 load_time with set_hour<=23 and set_min<=59 SHALL load hour and minute and clear tmp_second on the next edge; it overrides a same-cycle tick_1s, which is dropped.
REQ-018 load_alarm with in-range values SHALL update alarm_hour/alarm_min on the next edge; out-of-range values on either load SHALL be ignored in full, leaving all registers unchanged.
REQ-019 load_time and load_alarm in the same cycle SHALL both take effect.
REQ-020 A match event SHALL occur only when an accepted tick_1s advances the time to alarm_hour:alarm_min:00 while alarm_en=1; load_time never creates a match.
REQ-021 FSM states SHALL be IDLE, RING, SNOOZE.
REQ-022 IDLE -> RING on a match event; alarm rises on the same edge that the counters show the matched time.
REQ-023 In RING, alarm=1 and ring_cnt counts ticks; the FSM SHALL leave RING as follows:
- stop_alarm -> IDLE
- snooze -> SNOOZE, with snooze_cnt cleared
- ring_cnt reaching RING_SECONDS -> IDLE
- alarm_en=0 -> IDLE
REQ-024 In SNOOZE, alarm=0; the FSM SHALL go to RING after SNOOZE_SECONDS ticks, with ring_cnt cleared; stop_alarm or alarm_en=0 -> IDLE.
REQ-025 Priority when events coincide: alarm_en=0 > stop_alarm > snooze > counter expiry; snooze in IDLE or SNOOZE and stop_alarm in IDLE SHALL be ignored.
REQ-026 A match event while in RING or SNOOZE SHALL be ignored.
REQ-027 Timekeeping SHALL continue unaffected by FSM state.
REQ-028 ring_cnt and snooze_cnt SHALL be 8 bits wide and SHALL not overflow within the legal parameter ranges.

Reset
REQ-029 rst_n=0 SHALL immediately force the following, independent of clk:
- all time and alarm registers to 0
- ring_cnt and snooze_cnt to 0
- state to IDLE, alarm=0
REQ-030 Reset asserted mid-RING or mid-SNOOZE SHALL abort the alarm with no residual state; on deassertion the clock starts at 00:00:00.
REQ-031 Because reset leaves alarm_hour:alarm_min at 00:00, the first tick after reset (time 00:00:01) SHALL NOT match.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding, HOUR_MAX=23, MIN_MAX=59, SEC_MAX=59 and the 6-bit time-field width.
REQ-033 A single sub-module, mod_counter (parameterised modulus, enable in, carry out, async active-low reset), SHALL be instantiated three times as a chain for seconds, minutes and hours.

Verification
REQ-034 Reset, load_time 23:59, then 60 ticks -> 23:59:59 after tick 59, 00:00:00 after tick 60.
REQ-035 load_alarm 07:30, alarm_en=1, load_time 07:29, 60 ticks -> alarm rises with time 07:30:00; stop_alarm -> alarm=0 next edge.
REQ-036 Ringing, snooze -> alarm=0; after 30 ticks alarm=1 again; with no further input, alarm=0 after 60 more ticks.
REQ-037 load_time set_hour=24, set_min=10 -> time unchanged; load_time 10:20 coincident with tick_1s -> time 10:20:00, tick dropped.
REQ-038 Ringing, stop_alarm and snooze in the same cycle -> IDLE, with no re-ring after 30 ticks.
REQ-039 Ringing, rst_n pulsed low between clk edges -> alarm=0 and time 00:00:00 immediately, without waiting for a clk edge.
